// File: rtl/ld_pkg.sv
// Shared LD start-pulse timing constants and receiver FSM state type.
// Used by ld_start_rx and the matching pulse generator.
package ld_pkg;

    localparam int unsigned LD_HIGH_PERIOD  = 6;
    localparam int unsigned LD_TOTAL_PERIOD = 1250;
    localparam int unsigned LD_WIDTH_TOL    = 1;
    localparam int unsigned LD_PERIOD_TOL   = 2;
    localparam int unsigned LD_LOCK_COUNT   = 4;

    typedef enum logic [1:0] {
        ST_FIRST = 2'd0,
        ST_HIGH  = 2'd1,
        ST_LOW   = 2'd2
    } ld_state_e;

    function automatic logic [32:0] abs_diff33(
        input logic [32:0] a,
        input logic [32:0] b
    );
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer, asynchronous active-low reset.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_q    <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_q    <= r_meta;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/ld_start_rx.sv
// LD start pulse receiver: edge trigger, width/period measurement, lock.
// Define LD_START_RX_SYNC_EN to pass start_in through a 2-flop synchronizer.
module ld_start_rx
    import ld_pkg::*;
#(
    parameter int unsigned HIGH_PERIOD  = LD_HIGH_PERIOD,
    parameter int unsigned TOTAL_PERIOD = LD_TOTAL_PERIOD,
    parameter int unsigned WIDTH_TOL    = LD_WIDTH_TOL,
    parameter int unsigned PERIOD_TOL   = LD_PERIOD_TOL,
    parameter int unsigned LOCK_COUNT   = LD_LOCK_COUNT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_in,
    output logic        trig,
    output logic        meas_valid,
    output logic [15:0] meas_width,
    output logic [31:0] meas_period,
    output logic        err_width,
    output logic        err_period,
    output logic        err_timeout,
    output logic        lock
);

    localparam logic [31:0] TIMEOUT = 32'(2 * (TOTAL_PERIOD + 1));
    localparam logic [15:0] LOCK_N  = 16'(LOCK_COUNT);

    logic      w_s;
    logic      w_rdy;
    ld_state_e r_state;
    ld_state_e w_state_nxt;

    logic        r_s_d;
    logic        r_seen_low;
    logic [15:0] r_wcnt;
    logic [15:0] r_wlat;
    logic [31:0] r_pcnt;
    logic [15:0] r_good;

`ifdef LD_START_RX_SYNC_EN
    logic [1:0] r_prime;

    sync_2ff u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (start_in),
        .o_q   (w_s)
    );

    // Ignore the reset-flushed zeros until the synchronizer holds real samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prime <= 2'b00;
        end else begin
            r_prime <= {r_prime[0], 1'b1};
        end
    end

    assign w_rdy = r_prime[1];
`else
    assign w_s   = start_in;
    assign w_rdy = 1'b1;
`endif

    logic w_rise;
    logic w_fall;
    logic w_timeout;
    logic w_meas;
    logic w_err_w;
    logic w_err_p;

    assign w_rise    = w_s & ~r_s_d & r_seen_low;
    assign w_fall    = (r_state == ST_HIGH) & ~w_s;
    assign w_timeout = (r_state != ST_FIRST) & (r_pcnt == TIMEOUT) & ~w_rise;
    assign w_meas    = w_rise & (r_state == ST_LOW);

    assign w_err_w = abs_diff33({17'd0, r_wlat}, 33'(HIGH_PERIOD))
                     > 33'(WIDTH_TOL);
    assign w_err_p = abs_diff33({1'b0, r_pcnt}, 33'(TOTAL_PERIOD + 1))
                     > 33'(PERIOD_TOL);

    always_comb begin
        w_state_nxt = r_state;
        if (w_timeout) begin
            w_state_nxt = ST_FIRST;
        end else begin
            case (r_state)
                ST_FIRST: if (w_rise) w_state_nxt = ST_HIGH;
                ST_HIGH:  if (!w_s)   w_state_nxt = ST_LOW;
                ST_LOW:   if (w_rise) w_state_nxt = ST_HIGH;
                default:  w_state_nxt = ST_FIRST;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_FIRST;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s_d       <= 1'b0;
            r_seen_low  <= 1'b0;
            r_wcnt      <= '0;
            r_wlat      <= '0;
            r_pcnt      <= '0;
            r_good      <= '0;
            trig        <= 1'b0;
            meas_valid  <= 1'b0;
            meas_width  <= '0;
            meas_period <= '0;
            err_width   <= 1'b0;
            err_period  <= 1'b0;
            err_timeout <= 1'b0;
            lock        <= 1'b0;
        end else begin
            r_s_d       <= w_s;
            r_seen_low  <= r_seen_low | (~w_s & w_rdy);
            trig        <= w_rise;
            meas_valid  <= w_meas;
            err_timeout <= w_timeout;

            if (w_rise) begin
                r_wcnt <= 16'd1;
            end else if (r_state == ST_HIGH && w_s && r_wcnt != 16'hFFFF) begin
                r_wcnt <= r_wcnt + 16'd1;
            end

            if (w_fall) begin
                r_wlat <= r_wcnt;
            end

            if (w_rise) begin
                r_pcnt <= 32'd1;
            end else if (r_pcnt != 32'hFFFF_FFFF) begin
                r_pcnt <= r_pcnt + 32'd1;
            end

            // Lock updates in the same cycle the measurement is presented.
            if (w_meas) begin
                meas_width  <= r_wlat;
                meas_period <= r_pcnt;
                err_width   <= w_err_w;
                err_period  <= w_err_p;
                if (w_err_w || w_err_p) begin
                    r_good <= '0;
                    lock   <= 1'b0;
                end else begin
                    if (r_good < LOCK_N) begin
                        r_good <= r_good + 16'd1;
                    end
                    if (r_good + 16'd1 >= LOCK_N) begin
                        lock <= 1'b1;
                    end
                end
            end else if (w_timeout) begin
                r_good <= '0;
                lock   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ld_start_rx.sv
// Scoreboard bench for ld_start_rx (default build, direct sampling).
module tb_ld_start_rx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_in = 1'b0;
    logic        trig;
    logic        meas_valid;
    logic [15:0] meas_width;
    logic [31:0] meas_period;
    logic        err_width;
    logic        err_period;
    logic        err_timeout;
    logic        lock;

    ld_start_rx dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_in    (start_in),
        .trig        (trig),
        .meas_valid  (meas_valid),
        .meas_width  (meas_width),
        .meas_period (meas_period),
        .err_width   (err_width),
        .err_period  (err_period),
        .err_timeout (err_timeout),
        .lock        (lock)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit mv;
        int w;
        int p;
        bit ew;
        bit ep;
        bit lk;
    } exp_t;

    exp_t q[$];

    int n_chk = 0;
    int n_err = 0;
    int to_seen = 0;
    int to_exp = 0;

    bit m_have_ref = 0;
    int m_prev_h = 0;
    int m_prev_p = 0;
    int m_good = 0;
    bit m_lock = 0;

    task automatic chk(input string tag, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Expected behaviour for one drive of start_in: h cycles high, then low
    // until the next rise p cycles after this one.
    task automatic pulse(input int h, input int p);
        exp_t e;
        int d;
        int dp;
        e = '{mv: 0, w: 0, p: 0, ew: 0, ep: 0, lk: 0};
        if (m_have_ref) begin
            e.mv = 1;
            e.w  = m_prev_h;
            e.p  = m_prev_p;
            d  = (m_prev_h > 6) ? m_prev_h - 6 : 6 - m_prev_h;
            dp = (m_prev_p > 1251) ? m_prev_p - 1251 : 1251 - m_prev_p;
            e.ew = (d > 1);
            e.ep = (dp > 2);
            if (e.ew || e.ep) begin
                m_good = 0;
                m_lock = 0;
            end else begin
                if (m_good < 4) m_good++;
                if (m_good >= 4) m_lock = 1;
            end
        end
        e.lk = m_lock;
        q.push_back(e);
        m_have_ref = 1;
        m_prev_h = h;
        m_prev_p = p;
        start_in = 1'b1;
        repeat (h) begin
            @(posedge clk);
            #1;
        end
        start_in = 1'b0;
        repeat (p - h) begin
            @(posedge clk);
            #1;
        end
        if (p > 2502) begin
            to_exp++;
            m_have_ref = 0;
            m_good = 0;
            m_lock = 0;
            chk("lock_after_timeout", lock, 0);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (err_timeout) to_seen++;
            if (meas_valid && !trig) chk("mv_without_trig", 1, 0);
            if (trig) begin
                if (q.size() == 0) begin
                    chk("unexpected_trig", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("meas_valid", meas_valid, e.mv);
                    if (e.mv) begin
                        chk("meas_width", meas_width, e.w);
                        chk("meas_period", meas_period, e.p);
                        chk("err_width", err_width, e.ew);
                        chk("err_period", err_period, e.ep);
                    end
                    chk("lock", lock, e.lk);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4; i++) begin
            start_in = i[0];
            @(negedge clk);
            chk("reset_outs", {trig, meas_valid, meas_width, meas_period,
                err_width, err_period, err_timeout, lock}, 0);
        end
        start_in = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
        end

        for (int i = 0; i < 5; i++) pulse(6, 1251);
        chk("lock_nominal", lock, 1);

        pulse(9, 1251);
        pulse(6, 1260);
        for (int i = 0; i < 5; i++) pulse(6, 1251);
        chk("lock_relock", lock, 1);

        pulse(7, 1253);
        pulse(5, 1249);
        pulse(6, 1254);
        pulse(6, 1251);
        chk("lock_after_period_err", lock, 0);

        pulse(6, 2502);
        pulse(6, 2503);
        pulse(6, 1251);
        chk("timeouts_low", to_seen, to_exp);

        pulse(2600, 2700);
        pulse(6, 1251);
        pulse(6, 1251);
        chk("timeouts_high", to_seen, to_exp);

        start_in = 1'b1;
        q.push_back('{mv: m_have_ref, w: m_prev_h, p: m_prev_p,
                      ew: 0, ep: 0, lk: m_lock});
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        m_have_ref = 0;
        m_good = 0;
        m_lock = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("midpulse_reset_outs", {trig, meas_valid, meas_width,
                meas_period, err_width, err_period, err_timeout, lock}, 0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        start_in = 1'b0;
        repeat (20) begin
            @(posedge clk);
            #1;
        end
        pulse(6, 1251);
        pulse(6, 1251);

        repeat (5) @(posedge clk);
        chk("timeouts_total", to_seen, to_exp);
        chk("sb_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
